zigzag_serializer: RTL and testbench

ZIGZAG_SERIALIZER -- requirements
Module: zigzag_serializer

---
 rtl/zigzag_serializer_pkg.sv | 36 +++
 rtl/zigzag_serializer_if.sv | 33 +++
 rtl/zz_bank.sv | 25 ++
 rtl/zigzag_serializer.sv | 134 +++++++++++++
 tb/tb_zigzag_serializer.sv | 350 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/zigzag_serializer_pkg.sv
// Shared constants, bank states and the JPEG zigzag scan tables
// for the ping-pong 8x8 zigzag serializer.
package jpeg_zz_pkg;

  localparam int N = 8;

  typedef enum logic [1:0] {
    BANK_EMPTY,
    BANK_FILLING,
    BANK_FULL,
    BANK_DRAINING
  } bank_state_e;

  localparam logic [2:0] ZZ_ROW [64] = '{
    3'd0, 3'd0, 3'd1, 3'd2, 3'd1, 3'd0, 3'd0, 3'd1,
    3'd2, 3'd3, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd0,
    3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd5, 3'd4,
    3'd3, 3'd2, 3'd1, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3,
    3'd4, 3'd5, 3'd6, 3'd7, 3'd7, 3'd6, 3'd5, 3'd4,
    3'd3, 3'd2, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6,
    3'd7, 3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd4, 3'd5,
    3'd6, 3'd7, 3'd7, 3'd6, 3'd5, 3'd6, 3'd7, 3'd7
  };

  localparam logic [2:0] ZZ_COL [64] = '{
    3'd0, 3'd1, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd2,
    3'd1, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5,
    3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd0, 3'd1, 3'd2,
    3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd6, 3'd5, 3'd4,
    3'd3, 3'd2, 3'd1, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4,
    3'd5, 3'd6, 3'd7, 3'd7, 3'd6, 3'd5, 3'd4, 3'd3,
    3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd7, 3'd6,
    3'd5, 3'd4, 3'd5, 3'd6, 3'd7, 3'd7, 3'd6, 3'd7
  };

endpackage

// File: rtl/zigzag_serializer_if.sv
// Row-beat input and coefficient output bundle of the serializer.
// slave = serializer side, master = producer/consumer side.
interface zigzag_serializer_if #(
  parameter int W = 8
);
  logic              in_valid;
  logic [7:0][W-1:0] in_data;
  logic              in_sob;
  logic              in_eob;
  logic              in_sof;
  logic              in_ready;
  logic              out_valid;
  logic              out_ready;
  logic [W-1:0]      out_data;
  logic              out_sob;
  logic              out_eob;
  logic              out_sof;
  logic [1:0]        err;

  modport slave (
    input  in_valid, in_data, in_sob,
    input  in_eob, in_sof, out_ready,
    output in_ready, out_valid, out_data,
    output out_sob, out_eob, out_sof, err
  );

  modport master (
    output in_valid, in_data, in_sob,
    output in_eob, in_sof, out_ready,
    input  in_ready, out_valid, out_data,
    input  out_sob, out_eob, out_sof, err
  );
endinterface

// File: rtl/zz_bank.sv
// One 8x8 coefficient bank: whole-row write, single-element read.
// Contents are deliberately not reset; bank state lives in the top.
module zz_bank
  import jpeg_zz_pkg::*;
#(
  parameter int W = 8
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [2:0]        wrow_i,
  input  logic [N-1:0][W-1:0] wdata_i,
  input  logic [2:0]        rrow_i,
  input  logic [2:0]        rcol_i,
  output logic [W-1:0]      rdata_o
);

  logic [N-1:0][N-1:0][W-1:0] mem_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[wrow_i] <= wdata_i;
  end

  assign rdata_o = mem_q[rrow_i][rcol_i];

endmodule

// File: rtl/zigzag_serializer.sv
// Ping-pong 8x8 row collector that streams each block out
// one coefficient per beat in JPEG zigzag order.
module zigzag_serializer
  import jpeg_zz_pkg::*;
#(
  parameter int W = 8
) (
  input logic              clk,
  input logic              rst_n,
  zigzag_serializer_if.slave bus
);

  bank_state_e st_q [2];
  bank_state_e wst;
  logic        wp_q, rp_q, ign_q;
  logic [2:0]  row_q;
  logic [5:0]  k_q;
  logic [1:0]  sof_q, err_q;
  logic        ov_q, osob_q, oeob_q, osof_q;
  logic [W-1:0] od_q;

  logic        acc, rd_last, rd_start, chain, load, rsel;
  logic [5:0]  ridx;
  logic [W-1:0] rdat0, rdat1, rdata;
  logic        sob_ok, sob_ovf, fill, orphan, we;
  logic        done, bad_eob, restart;
  logic [2:0]  wrow;

  assign acc      = ov_q && bus.out_ready;
  assign rd_last  = acc && (k_q == 6'd63);
  assign rd_start = !ov_q && (st_q[rp_q] == BANK_FULL);
  assign chain    = rd_last && (st_q[~rp_q] == BANK_FULL);
  assign load     = rd_start || chain || (acc && !rd_last);
  assign rsel     = rd_last ? ~rp_q : rp_q;
  assign ridx     = k_q + {5'd0, acc};
  assign rdata    = rsel ? rdat1 : rdat0;

  // A bank released by the drain this cycle is writable now.
  assign wst = (rd_last && (rp_q == wp_q)) ? BANK_EMPTY
                                           : st_q[wp_q];

  assign sob_ok  = bus.in_valid && bus.in_sob &&
                   (wst == BANK_EMPTY || wst == BANK_FILLING);
  assign sob_ovf = bus.in_valid && bus.in_sob &&
                   (wst == BANK_FULL || wst == BANK_DRAINING);
  assign fill    = bus.in_valid && !bus.in_sob && !ign_q &&
                   (wst == BANK_FILLING);
  assign orphan  = bus.in_valid && !bus.in_sob && !ign_q &&
                   (wst != BANK_FILLING);
  assign restart = sob_ok && (wst == BANK_FILLING);
  assign we      = sob_ok || fill;
  assign wrow    = bus.in_sob ? 3'd0 : row_q;
  assign done    = we && bus.in_eob && (wrow == 3'd7);
  assign bad_eob = we && bus.in_eob && (wrow != 3'd7);

  zz_bank #(.W(W)) u_bank0 (
    .clk     (clk),
    .we_i    (we && !wp_q),
    .wrow_i  (wrow),
    .wdata_i (bus.in_data),
    .rrow_i  (ZZ_ROW[ridx]),
    .rcol_i  (ZZ_COL[ridx]),
    .rdata_o (rdat0)
  );

  zz_bank #(.W(W)) u_bank1 (
    .clk     (clk),
    .we_i    (we && wp_q),
    .wrow_i  (wrow),
    .wdata_i (bus.in_data),
    .rrow_i  (ZZ_ROW[ridx]),
    .rcol_i  (ZZ_COL[ridx]),
    .rdata_o (rdat1)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q[0] <= BANK_EMPTY;
      st_q[1] <= BANK_EMPTY;
      wp_q    <= 1'b0;
      rp_q    <= 1'b0;
      ign_q   <= 1'b0;
      row_q   <= 3'd0;
      k_q     <= 6'd0;
      sof_q   <= 2'b00;
      err_q   <= 2'b00;
      ov_q    <= 1'b0;
      od_q    <= '0;
      osob_q  <= 1'b0;
      oeob_q  <= 1'b0;
      osof_q  <= 1'b0;
    end else begin
      if (rd_start) st_q[rp_q] <= BANK_DRAINING;
      if (rd_last) begin
        st_q[rp_q] <= BANK_EMPTY;
        rp_q       <= ~rp_q;
      end
      if (chain) st_q[~rp_q] <= BANK_DRAINING;
      if (acc || rd_start) k_q <= ridx;
      if (load) begin
        ov_q   <= 1'b1;
        od_q   <= rdata;
        osob_q <= (ridx == 6'd0);
        oeob_q <= (ridx == 6'd63);
        osof_q <= (ridx == 6'd0) && sof_q[rsel];
      end else if (rd_last) begin
        ov_q   <= 1'b0;
        osob_q <= 1'b0;
        oeob_q <= 1'b0;
        osof_q <= 1'b0;
      end
      // Write side last so a same-cycle refill wins over the release.
      if (we) begin
        st_q[wp_q] <= done    ? BANK_FULL  :
                      bad_eob ? BANK_EMPTY : BANK_FILLING;
        row_q <= wrow + 3'd1;
      end
      if (done) wp_q <= ~wp_q;
      if (sob_ok) sof_q[wp_q] <= bus.in_sof;
      if (bus.in_valid && bus.in_sob) ign_q <= sob_ovf;
      err_q <= err_q | {restart || orphan || bad_eob, sob_ovf};
    end
  end

  assign bus.in_ready  = (st_q[wp_q] == BANK_EMPTY) ||
                         (st_q[wp_q] == BANK_FILLING);
  assign bus.out_valid = ov_q;
  assign bus.out_data  = od_q;
  assign bus.out_sob   = osob_q;
  assign bus.out_eob   = oeob_q;
  assign bus.out_sof   = osof_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_zigzag_serializer.sv
// Directed bench for zigzag_serializer: ordering, flags, stalls,
// back-to-back blocks, framing/overflow errors and async reset.
module tb_zigzag_serializer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vec = 0;
  int   miss = 0;

  zigzag_serializer_if #(.W(8)) bus ();

  zigzag_serializer #(.W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // Hand-derived zigzag stream for element (r,c) = r*8+c+1.
  int exp_zz [64] = '{
     1,  2,  9, 17, 10,  3,  4, 11,
    18, 25, 33, 26, 19, 12,  5,  6,
    13, 20, 27, 34, 41, 49, 42, 35,
    28, 21, 14,  7,  8, 15, 22, 29,
    36, 43, 50, 57, 58, 51, 44, 37,
    30, 23, 16, 24, 31, 38, 45, 52,
    59, 60, 53, 46, 39, 32, 40, 47,
    54, 61, 62, 55, 48, 56, 63, 64
  };

  logic [7:0] cap_data [256];
  bit         cap_sob [256];
  bit         cap_eob [256];
  bit         cap_sof [256];
  int         cap_n, cap_gaps, stall_changes;
  logic [7:0] stall_first;

  task automatic idle_in();
    bus.in_valid = 1'b0;
    bus.in_sob   = 1'b0;
    bus.in_eob   = 1'b0;
    bus.in_sof   = 1'b0;
    bus.in_data  = '0;
  endtask

  task automatic do_reset();
    idle_in();
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Rows r0..r1-1; sob on row 0, eob on row eob_row.
  task automatic send_rows(input int off, input bit sof,
                           input int r0, input int r1,
                           input int eob_row);
    for (int r = r0; r < r1; r++) begin
      bus.in_valid = 1'b1;
      for (int c = 0; c < 8; c++)
        bus.in_data[c] = 8'(r * 8 + c + 1 + off);
      bus.in_sob = (r == 0);
      bus.in_sof = (r == 0) && sof;
      bus.in_eob = (r == eob_row);
      @(posedge clk);
      #1;
    end
    idle_in();
  endtask

  // Collects output beats; optionally stalls at one beat index.
  task automatic drain(input int maxb, input int budget,
                       input int stall_at, input int stall_len);
    int  cyc = 0;
    int  stalled = 0;
    bit  started = 0;
    logic [10:0] hold = '0;
    cap_n = 0;
    cap_gaps = 0;
    stall_changes = 0;
    while (cap_n < maxb && cyc < budget) begin
      if (cap_n == stall_at && stalled < stall_len && bus.out_valid) begin
        bus.out_ready = 1'b0;
        if (stalled == 0) begin
          hold = {bus.out_data, bus.out_sob, bus.out_eob, bus.out_sof};
          stall_first = bus.out_data;
        end else if ({bus.out_data, bus.out_sob, bus.out_eob,
                      bus.out_sof} !== hold || !bus.out_valid) begin
          stall_changes++;
        end
        stalled++;
      end else begin
        bus.out_ready = 1'b1;
        if (bus.out_valid) begin
          cap_data[cap_n] = bus.out_data;
          cap_sob[cap_n]  = bus.out_sob;
          cap_eob[cap_n]  = bus.out_eob;
          cap_sof[cap_n]  = bus.out_sof;
          cap_n++;
          started = 1;
        end else if (started) begin
          cap_gaps++;
        end
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    bus.out_ready = 1'b0;
    idle_in();
    rst_n = 1'b0;
    #3;
    vec++;
    if ({bus.out_valid, bus.out_sob, bus.out_eob, bus.out_sof,
         bus.out_data, bus.err, bus.in_ready} !== 15'b0000_00000000_00_1) begin
      miss++;
      $display("FAIL reset_state got v%b s%b e%b f%b d%h err%b rdy%b want all 0, rdy 1",
               bus.out_valid, bus.out_sob, bus.out_eob, bus.out_sof,
               bus.out_data, bus.err, bus.in_ready);
    end
    do_reset();
  endtask

  task automatic test_single_block();
    do_reset();
    send_rows(0, 0, 0, 8, 7);
    vec++;
    if (bus.out_valid !== 1'b0) begin
      miss++;
      $display("FAIL latency_early out_valid got %b want 0", bus.out_valid);
    end
    @(posedge clk);
    #1;
    vec++;
    if ({bus.out_valid, bus.out_sob, bus.out_data} !== {2'b11, 8'd1}) begin
      miss++;
      $display("FAIL latency_first got v%b s%b d%0d want v1 s1 d1",
               bus.out_valid, bus.out_sob, bus.out_data);
    end
    drain(64, 200, -1, 0);
    vec++;
    if (cap_n !== 64 || cap_gaps !== 0) begin
      miss++;
      $display("FAIL single_count got %0d beats %0d gaps want 64 0", cap_n, cap_gaps);
    end
    for (int k = 0; k < 64; k++) begin
      vec++;
      if ({cap_data[k], cap_sob[k], cap_eob[k]} !==
          {8'(exp_zz[k]), k == 0, k == 63}) begin
        miss++;
        $display("FAIL single_beat%0d got d%0d s%b e%b want d%0d s%b e%b",
                 k, cap_data[k], cap_sob[k], cap_eob[k],
                 exp_zz[k], k == 0, k == 63);
      end
    end
    vec++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.err !== 2'b00) begin
      miss++;
      $display("FAIL single_idle got v%b rdy%b err%b want 0 1 00",
               bus.out_valid, bus.in_ready, bus.err);
    end
  endtask

  task automatic test_sof();
    do_reset();
    send_rows(0, 1, 0, 8, 7);
    send_rows(64, 0, 0, 8, 7);
    drain(128, 300, -1, 0);
    vec++;
    if (cap_n !== 128) begin
      miss++;
      $display("FAIL sof_count got %0d want 128", cap_n);
    end
    for (int k = 0; k < 128; k++) begin
      vec++;
      if (cap_sof[k] !== (k == 0)) begin
        miss++;
        $display("FAIL sof_beat%0d got %b want %b", k, cap_sof[k], k == 0);
      end
    end
    vec++;
    if (cap_data[64] !== 8'd65 || cap_sob[64] !== 1'b1) begin
      miss++;
      $display("FAIL sof_block2_first got d%0d s%b want d65 s1",
               cap_data[64], cap_sob[64]);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    fork
      begin
        send_rows(0, 0, 0, 8, 7);
        send_rows(64, 0, 0, 8, 7);
        send_rows(128, 0, 0, 1, 7);
        vec++;
        if (bus.err !== 2'b01 || bus.in_ready !== 1'b0) begin
          miss++;
          $display("FAIL b2b_overflow got err%b rdy%b want 01 0",
                   bus.err, bus.in_ready);
        end
        send_rows(128, 0, 1, 8, 7);
      end
      drain(128, 400, -1, 0);
    join
    vec++;
    if (cap_n !== 128 || cap_gaps !== 0) begin
      miss++;
      $display("FAIL b2b_count got %0d beats %0d gaps want 128 0", cap_n, cap_gaps);
    end
    for (int k = 0; k < 128; k++) begin
      vec++;
      if (cap_data[k] !== 8'(exp_zz[k % 64] + (k / 64) * 64) ||
          cap_sob[k] !== (k % 64 == 0) || cap_eob[k] !== (k % 64 == 63)) begin
        miss++;
        $display("FAIL b2b_beat%0d got d%0d s%b e%b want d%0d s%b e%b",
                 k, cap_data[k], cap_sob[k], cap_eob[k],
                 exp_zz[k % 64] + (k / 64) * 64, k % 64 == 0, k % 64 == 63);
      end
    end
    repeat (5) @(posedge clk);
    #1;
    vec++;
    if (bus.out_valid !== 1'b0 || bus.err !== 2'b01) begin
      miss++;
      $display("FAIL b2b_after got v%b err%b want 0 01", bus.out_valid, bus.err);
    end
  endtask

  task automatic test_stall();
    do_reset();
    send_rows(0, 0, 0, 8, 7);
    drain(64, 300, 5, 10);
    vec++;
    if (stall_first !== 8'd3 || stall_changes !== 0) begin
      miss++;
      $display("FAIL stall_hold got first %0d changes %0d want 3 0",
               stall_first, stall_changes);
    end
    vec++;
    if (cap_n !== 64 || cap_data[5] !== 8'd3 || cap_data[6] !== 8'd4) begin
      miss++;
      $display("FAIL stall_stream got n%0d b5=%0d b6=%0d want 64 3 4",
               cap_n, cap_data[5], cap_data[6]);
    end
    vec++;
    if (cap_data[63] !== 8'd64 || cap_eob[63] !== 1'b1) begin
      miss++;
      $display("FAIL stall_last got d%0d e%b want 64 1", cap_data[63], cap_eob[63]);
    end
  endtask

  task automatic test_framing();
    int seen = 0;
    do_reset();
    send_rows(0, 0, 0, 5, 4);
    vec++;
    if (bus.err !== 2'b10 || bus.in_ready !== 1'b1) begin
      miss++;
      $display("FAIL frame_err got err%b rdy%b want 10 1", bus.err, bus.in_ready);
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (bus.out_valid) seen++;
      @(posedge clk);
      #1;
    end
    vec++;
    if (seen !== 0) begin
      miss++;
      $display("FAIL frame_no_output got %0d valid cycles want 0", seen);
    end
    send_rows(16, 0, 0, 8, 7);
    drain(64, 200, -1, 0);
    vec++;
    if (cap_n !== 64 || cap_data[0] !== 8'd17 || cap_data[2] !== 8'd25 ||
        cap_data[63] !== 8'd80) begin
      miss++;
      $display("FAIL frame_recover got n%0d d0=%0d d2=%0d d63=%0d want 64 17 25 80",
               cap_n, cap_data[0], cap_data[2], cap_data[63]);
    end
    vec++;
    if (bus.err !== 2'b10) begin
      miss++;
      $display("FAIL frame_sticky got err%b want 10", bus.err);
    end
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    send_rows(0, 1, 0, 8, 7);
    drain(30, 200, -1, 0);
    vec++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'(exp_zz[30])) begin
      miss++;
      $display("FAIL mid_beat30 got v%b d%0d want 1 %0d",
               bus.out_valid, bus.out_data, exp_zz[30]);
    end
    rst_n = 1'b0;
    #1;
    vec++;
    if ({bus.out_valid, bus.out_sob, bus.out_eob, bus.out_sof,
         bus.out_data, bus.err, bus.in_ready} !== 15'b0000_00000000_00_1) begin
      miss++;
      $display("FAIL mid_reset got v%b d%h err%b rdy%b want 0 00 00 1",
               bus.out_valid, bus.out_data, bus.err, bus.in_ready);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_rows(0, 0, 0, 8, 7);
    drain(64, 200, -1, 0);
    vec++;
    if (cap_n !== 64 || cap_data[0] !== 8'd1 || cap_sob[0] !== 1'b1 ||
        cap_data[63] !== 8'd64 || cap_eob[63] !== 1'b1) begin
      miss++;
      $display("FAIL mid_after got n%0d d0=%0d d63=%0d want 64 1 64",
               cap_n, cap_data[0], cap_data[63]);
    end
  endtask

  initial begin
    idle_in();
    bus.out_ready = 1'b0;
    test_reset();
    test_single_block();
    test_sof();
    test_back_to_back();
    test_stall();
    test_framing();
    test_reset_mid_drain();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
